// File: rtl/pcie_pkg.sv
// Shared definitions for the CQ request adapter: descriptor field offsets,
// request-type codes, legacy fmt/type bytes, legacy tuser bit positions,
// FSM state encoding and small remap helpers.
package pcie_pkg;

    localparam int CQ_DATA_W = 128;
    localparam int A_KEEP_W  = 16;
    localparam int A_USER_W  = 22;
    localparam int SKID_W    = CQ_DATA_W + A_KEEP_W + A_USER_W + 1;

    // CQ descriptor field offsets (dword-aligned mode, descriptor fills beat 0)
    localparam int DESC_DWCNT_LO = 64;
    localparam int DESC_DWCNT_HI = 74;
    localparam int DESC_RT_LO    = 75;
    localparam int DESC_RT_HI    = 78;
    localparam int DESC_REQID_LO = 80;
    localparam int DESC_REQID_HI = 95;
    localparam int DESC_TAG_LO   = 96;
    localparam int DESC_TAG_HI   = 103;
    localparam int DESC_BAR_LO   = 112;
    localparam int DESC_BAR_HI   = 114;
    localparam int DESC_TC_LO    = 121;
    localparam int DESC_TC_HI    = 123;
    localparam int DESC_ATTR_LO  = 124;
    localparam int DESC_ATTR_HI  = 126;

    // CQ tuser bit positions
    localparam int CQU_FBE_LO = 0;
    localparam int CQU_FBE_HI = 3;
    localparam int CQU_LBE_LO = 8;
    localparam int CQU_LBE_HI = 11;
    localparam int CQU_SOP    = 40;
    localparam int CQU_DISC   = 41;

    // Legacy tuser bit positions
    localparam int TUA_BAR_LO = 0;
    localparam int TUA_BAR_HI = 6;
    localparam int TUA_DISC   = 7;
    localparam int TUA_UNSUP  = 8;

    // CQ request-type codes
    localparam logic [3:0] RT_MRD   = 4'b0000;
    localparam logic [3:0] RT_MWR   = 4'b0001;
    localparam logic [3:0] RT_IORD  = 4'b0010;
    localparam logic [3:0] RT_IOWR  = 4'b0011;
    localparam logic [3:0] RT_MRDLK = 4'b0111;

    // Legacy fmt/type bytes
    localparam logic [7:0] FT_MRD_3DW   = 8'h00;
    localparam logic [7:0] FT_MRD_4DW   = 8'h20;
    localparam logic [7:0] FT_MWR_3DW   = 8'h40;
    localparam logic [7:0] FT_MWR_4DW   = 8'h60;
    localparam logic [7:0] FT_IORD      = 8'h02;
    localparam logic [7:0] FT_IOWR      = 8'h42;
    localparam logic [7:0] FT_MRDLK_3DW = 8'h01;
    localparam logic [7:0] FT_MRDLK_4DW = 8'h21;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } cq_state_e;

    // BAR id to one-hot hit vector; id 7 is not a BAR and maps to no hit
    function automatic logic [6:0] bar_onehot(input logic [2:0] barid);
        logic [6:0] r;
        if (barid == 3'd7) begin
            r = 7'd0;
        end else begin
            r = 7'd1 << barid;
        end
        return r;
    endfunction

    // Per-dword keep to per-byte enables
    function automatic logic [15:0] keep_expand(input logic [3:0] k);
        logic [15:0] r;
        r = 16'd0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = {4{k[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_skid_x4.sv
// Two-entry skid buffer: registered output stage plus one overflow slot.
// Upstream ready is registered and drops only when the overflow slot is full,
// so full throughput is kept while downstream is ready.
module axis_skid_x4
    import pcie_pkg::*;
#(
    parameter int DAT_B = SKID_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    input  logic [DAT_B-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [DAT_B-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             out_valid_q, out_valid_d;
    logic [DAT_B-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [DAT_B-1:0] skid_data_q, skid_data_d;
    logic             ready_q;
    logic             in_fire_s;

    // Next-state of output stage and overflow slot
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        in_fire_s    = in_valid_i & ready_q;
        if (out_ready_i || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire_s) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data_i;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // Buffer state registers; ready mirrors the overflow slot being empty
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ~skid_valid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/m_axis_cq_adapt_x4.sv
// CQ-to-legacy request adapter: decodes the CQ descriptor beat into a 3DW/4DW
// legacy TLP header, passes payload through with byte-enable expansion, and
// drops unsupported, malformed or discontinued remainder beats.
module m_axis_cq_adapt_x4
    import pcie_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter bit DROP_UNSUP = 1'b1
) (
    input  logic                  user_clk,
    input  logic                  user_reset_n,
    input  logic [DATA_WIDTH-1:0] m_axis_cq_tdata,
    input  logic [3:0]            m_axis_cq_tkeep,
    input  logic                  m_axis_cq_tlast,
    input  logic [84:0]           m_axis_cq_tuser,
    input  logic                  m_axis_cq_tvalid,
    output logic [21:0]           m_axis_cq_tready,
    output logic [DATA_WIDTH-1:0] m_axis_cq_tdata_a,
    output logic [KEEP_WIDTH-1:0] m_axis_cq_tkeep_a,
    output logic                  m_axis_cq_tlast_a,
    output logic [21:0]           m_axis_cq_tuser_a,
    output logic                  m_axis_cq_tvalid_a,
    input  logic                  m_axis_cq_tready_a
);

    localparam int SK_W = DATA_WIDTH + KEEP_WIDTH + A_USER_W + 1;

    cq_state_e             state_q, state_d;
    logic [6:0]            bar_q, bar_d;
    logic                  unsup_q, unsup_d;
    logic                  skid_ready_s, cq_fire_s, emit_s;
    logic                  supported_s, use4_s;
    logic [7:0]            fmt_type_s;
    logic [31:0]           hdr_dw0_s, hdr_dw1_s;
    logic [DATA_WIDTH-1:0] hdr_data_s, out_data_s;
    logic [KEEP_WIDTH-1:0] out_keep_s;
    logic                  out_last_s;
    logic [21:0]           out_user_s;
    logic [SK_W-1:0]       skid_out_s;
    logic                  unused_s;

    assign cq_fire_s = m_axis_cq_tvalid & skid_ready_s;
    assign unused_s  = ^{m_axis_cq_tuser[84:42], m_axis_cq_tuser[39:12], m_axis_cq_tuser[7:4]};

    // Descriptor decode: request type to fmt/type and header layout
    always_comb begin
        supported_s = 1'b1;
        use4_s      = 1'b0;
        fmt_type_s  = 8'h00;
        case (m_axis_cq_tdata[DESC_RT_HI:DESC_RT_LO])
            RT_MRD: begin
                use4_s     = |m_axis_cq_tdata[63:32];
                fmt_type_s = use4_s ? FT_MRD_4DW : FT_MRD_3DW;
            end
            RT_MWR: begin
                use4_s     = |m_axis_cq_tdata[63:32];
                fmt_type_s = use4_s ? FT_MWR_4DW : FT_MWR_3DW;
            end
            RT_IORD:  fmt_type_s = FT_IORD;
            RT_IOWR:  fmt_type_s = FT_IOWR;
            RT_MRDLK: begin
                use4_s     = |m_axis_cq_tdata[63:32];
                fmt_type_s = use4_s ? FT_MRDLK_4DW : FT_MRDLK_3DW;
            end
            default: begin
                supported_s = 1'b0;
                fmt_type_s  = 8'h00;
            end
        endcase
        hdr_dw0_s = {fmt_type_s, 1'b0, m_axis_cq_tdata[DESC_TC_HI:DESC_TC_LO], 4'b0000,
                     1'b0, 1'b0, m_axis_cq_tdata[DESC_ATTR_LO+1:DESC_ATTR_LO], 2'b00,
                     m_axis_cq_tdata[DESC_DWCNT_LO+9:DESC_DWCNT_LO]};
        hdr_dw1_s = {m_axis_cq_tdata[DESC_REQID_HI:DESC_REQID_LO],
                     m_axis_cq_tdata[DESC_TAG_HI:DESC_TAG_LO],
                     m_axis_cq_tuser[CQU_LBE_HI:CQU_LBE_LO],
                     m_axis_cq_tuser[CQU_FBE_HI:CQU_FBE_LO]};
        hdr_data_s = use4_s ?
            {m_axis_cq_tdata[31:2], 2'b00, m_axis_cq_tdata[63:32], hdr_dw1_s, hdr_dw0_s} :
            {32'h0000_0000, m_axis_cq_tdata[31:2], 2'b00, hdr_dw1_s, hdr_dw0_s};
    end

    // Packet FSM next-state and output-beat formation
    always_comb begin
        state_d    = state_q;
        bar_d      = bar_q;
        unsup_d    = unsup_q;
        emit_s     = 1'b0;
        out_data_s = m_axis_cq_tdata;
        out_keep_s = keep_expand(m_axis_cq_tkeep);
        out_last_s = m_axis_cq_tlast;
        out_user_s = 22'd0;
        if (cq_fire_s) begin
            case (state_q)
                ST_HDR: begin
                    if (!m_axis_cq_tuser[CQU_SOP]) begin
                        state_d = m_axis_cq_tlast ? ST_HDR : ST_DROP;
                    end else if (!supported_s && DROP_UNSUP) begin
                        state_d = m_axis_cq_tlast ? ST_HDR : ST_DROP;
                    end else begin
                        emit_s     = 1'b1;
                        bar_d      = bar_onehot(m_axis_cq_tdata[DESC_BAR_HI:DESC_BAR_LO]);
                        unsup_d    = ~supported_s;
                        out_data_s = hdr_data_s;
                        out_keep_s = use4_s ? 16'hFFFF : 16'h0FFF;
                        out_user_s[TUA_BAR_HI:TUA_BAR_LO] = bar_d;
                        out_user_s[TUA_UNSUP] = ~supported_s;
                        if (m_axis_cq_tuser[CQU_DISC]) begin
                            out_last_s           = 1'b1;
                            out_user_s[TUA_DISC] = 1'b1;
                            state_d = m_axis_cq_tlast ? ST_HDR : ST_DROP;
                        end else begin
                            state_d = m_axis_cq_tlast ? ST_HDR : ST_FWD;
                        end
                    end
                end
                ST_FWD: begin
                    emit_s = 1'b1;
                    out_user_s[TUA_BAR_HI:TUA_BAR_LO] = bar_q;
                    out_user_s[TUA_UNSUP] = unsup_q;
                    if (m_axis_cq_tuser[CQU_DISC]) begin
                        out_last_s           = 1'b1;
                        out_user_s[TUA_DISC] = 1'b1;
                        state_d = m_axis_cq_tlast ? ST_HDR : ST_DROP;
                    end else begin
                        state_d = m_axis_cq_tlast ? ST_HDR : ST_FWD;
                    end
                end
                ST_DROP: state_d = m_axis_cq_tlast ? ST_HDR : ST_DROP;
                default: state_d = ST_HDR;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM state and per-packet BAR/unsupported attributes
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q <= ST_HDR;
            bar_q   <= 7'd0;
            unsup_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bar_q   <= bar_d;
            unsup_q <= unsup_d;
        end
    end

    axis_skid_x4 #(
        .DAT_B(SK_W)
    ) u_skid (
        .clk_i       (user_clk),
        .rst_n_i     (user_reset_n),
        .in_valid_i  (emit_s),
        .in_data_i   ({out_last_s, out_user_s, out_keep_s, out_data_s}),
        .in_ready_o  (skid_ready_s),
        .out_valid_o (m_axis_cq_tvalid_a),
        .out_data_o  (skid_out_s),
        .out_ready_i (m_axis_cq_tready_a)
    );

    assign {m_axis_cq_tlast_a, m_axis_cq_tuser_a, m_axis_cq_tkeep_a, m_axis_cq_tdata_a} = skid_out_s;
    assign m_axis_cq_tready = {22{skid_ready_s}};

endmodule
